// File: rtl/ysyx_23060236_ifu.sv
// ysyx_23060236_ifu: fetch unit with BTB-predicted PC, a single outstanding imem read and a redirect flush.
// Define YSYX_23060236_IFU_PERF_EN to add the fetch/drop performance counter ports.
module ysyx_23060236_ifu #(
    parameter int DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h3000_0000
) (
    input  logic                clock,
    input  logic                reset,
    output logic [DATA_LEN-1:0] btb_araddr,
    input  logic [DATA_LEN-1:0] btb_rdata,
    output logic                imem_arvalid,
    output logic [DATA_LEN-1:0] imem_araddr,
    input  logic                imem_arready,
    input  logic                imem_rvalid,
    input  logic [DATA_LEN-1:0] imem_rdata,
    output logic                imem_rready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_inst,
    output logic [DATA_LEN-1:0] out_pc,
    output logic [DATA_LEN-1:0] out_pred_npc,
    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc
`ifdef YSYX_23060236_IFU_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_drop_cnt
`endif
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DROP} state_t;
    state_t state_q, state_d;
    logic [DATA_LEN-1:0] pc_q, pc_d, inst_q, inst_d, pred_q, pred_d, req_q, req_d;
    logic drop_pq, drop_pd, fire;
    assign btb_araddr = pc_q;
    assign imem_arvalid = ~reset & (state_q == S_REQ);
    // a request made before a redirect keeps its original address until accepted
    assign imem_araddr = drop_pq ? req_q : pc_q;
    assign imem_rready = ~reset & (state_q == S_WAIT | state_q == S_DROP);
    assign out_valid = ~reset & (state_q == S_OUT) & ~redirect_valid;
    assign out_inst = inst_q;
    assign out_pc = pc_q;
    assign out_pred_npc = pred_q;
    assign fire = out_valid & out_ready;
    always_comb begin
        state_d = state_q;
        pc_d = pc_q;
        inst_d = inst_q;
        pred_d = pred_q;
        req_d = req_q;
        drop_pd = drop_pq;
        case (state_q)
            S_REQ:
                if (imem_arready) begin
                    state_d = (redirect_valid | drop_pq) ? S_DROP : S_WAIT;
                    pred_d = btb_rdata;
                    drop_pd = 1'b0;
                end else if (redirect_valid & ~drop_pq) begin
                    drop_pd = 1'b1;
                    req_d = pc_q;
                end
            S_WAIT:
                if (imem_rvalid) begin
                    state_d = redirect_valid ? S_REQ : S_OUT;
                    inst_d = redirect_valid ? inst_q : imem_rdata;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            S_OUT:
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (fire) begin
                    state_d = S_REQ;
                    pc_d = pred_q;
                end
            S_DROP:
                if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
        if (redirect_valid) pc_d = redirect_pc;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q <= RESET_PC;
            inst_q <= '0;
            pred_q <= '0;
            req_q <= '0;
            drop_pq <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            inst_q <= inst_d;
            pred_q <= pred_d;
            req_q <= req_d;
            drop_pq <= drop_pd;
        end
    end
`ifdef YSYX_23060236_IFU_PERF_EN
    logic drop_hit;
    logic [31:0] fetch_cnt_q, drop_cnt_q;
    assign drop_hit = (redirect_valid & (state_q == S_OUT | (state_q == S_WAIT & imem_rvalid)))
                    | (state_q == S_DROP & imem_rvalid);
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_drop_cnt = drop_cnt_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, fire};
            drop_cnt_q <= drop_cnt_q + {31'd0, drop_hit};
        end
    end
`endif
endmodule
